acc_datapath: RTL and testbench
===============================

# acc_datapath

Parametrised accumulator datapath for the BIP-style CPU core. It adds a full ALU op set, configurable operand extension, status flags and an optional iterative multiplier with a busy/done handshake. It sits between the control unit, which drives the select, write and op signals, and data memory, which supplies the read data. The accumulator is exported to memory write data and to the branch logic.

## Interface
- NBITS_O, 11, instruction operand width; must be ≤ NBITS_D
- NBITS_D, 16, data/accumulator width
- SIGN_EXT, 1, 1 = sign-extend operand to NBITS_D, 0 = zero-extend

- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_SelA  in  2  accumulator source: 00 memory data, 01 ALU result, 10 extended operand, 11 reserved (hold)
- i_SelB  in  1  ALU B operand: 0 memory data, 1 extended operand
- i_WrAcc  in  1  accumulator write enable
- i_Op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1 (A), 110 SRA1 (A), 111 PASSB
- i_MulStart  in  1  start multiply, sampled only when idle
- i_Operand  in  NBITS_O  immediate from instruction
- i_OutData  in  NBITS_D  data memory read data
- o_Acc  out  NBITS_D  accumulator
- o_Zero, o_Neg, o_Carry  out  1 each  status flags
- o_Busy  out  1  multiplier running
- o_MulDone  out  1  one-cycle completion pulse

## Operation
- ALU is combinational with A = accumulator and B = mux(i_SelB). The result is NBITS_D bits and wraps modulo 2^NBITS_D.
- On a rising edge with i_WrAcc=1 and o_Busy=0, the accumulator loads the source selected by i_SelA. SelA=11 means hold.
- Flags update only on a write with SelA=01, or on multiply completion:
  - Zero: result == 0.
  - Neg: result MSB.
  - Carry: ADD carry-out; SUB borrow (A < B unsigned); SHL1 the shifted-out MSB; SRA1 the shifted-out LSB; all other ops 0.
- Loads with SelA=00 or SelA=10 leave the flags unchanged.
- Multiplier FSM has three states: IDLE → RUN → DONE → IDLE.
  - IDLE, i_MulStart=1: capture multiplicand = o_Acc (pre-edge value) and multiplier = B, clear the product, set counter to NBITS_D. Go to RUN.
  - RUN: one shift-add step per cycle. Counter decrements; at 0 go to DONE.
  - DONE: accumulator ← low NBITS_D bits of the unsigned product. Flags update (Zero, Neg; Carry = 1 if any high product bit is nonzero). o_MulDone=1 for this cycle. Go to IDLE.
- o_Busy=1 in RUN and DONE. While busy, i_WrAcc and i_MulStart are ignored.
- i_WrAcc and i_MulStart together in IDLE: the write takes effect, and the multiplier captures the pre-write accumulator.
- Reset values, applied asynchronously on i_reset=0:
  - o_Acc=0; all flags 0; o_Busy=0; o_MulDone=0; FSM in IDLE; counter 0.
  - Reset mid-multiply aborts the operation with no completion pulse.

## Timing
- Accumulator write latency: 1 edge. ALU and flag inputs are sampled on the same edge.
- Multiply latency: o_Busy rises the edge after start and stays high for NBITS_D + 1 cycles. o_MulDone and the new o_Acc both appear on the last of those cycles.
- A new start is accepted in the first cycle with o_Busy=0.

## Configuration
- ACC_DATAPATH_MUL_EN defined: multiplier FSM present as described above.
- Undefined:
  - No multiplier logic; i_MulStart is ignored.
  - o_Busy and o_MulDone are tied to 0.
  - Accumulator writes are never blocked.

## Structure
- Package acc_datapath_pkg holds the ALU op codes, the SelA/SelB codes and the multiplier FSM state enum.
- Sub-module acc_mul_seq: sequential shift-add multiplier with start/busy/done handshake. Instantiated only under ACC_DATAPATH_MUL_EN. The ALU and muxes stay in the top module.

## Test plan
Defaults NBITS_O=11, NBITS_D=16, SIGN_EXT=1.
- Reset: drive i_reset=0 mid-traffic → o_Acc=0x0000, all flags 0, o_Busy=0, without waiting for a clock edge.
- Operand load: Operand=0x07B, SelA=10, WrAcc pulse → o_Acc=0x007B. Operand=0x7FF → 0xFFFF (with SIGN_EXT=0 → 0x07FF). Flags unchanged.
- ADD: Acc=0x007B, OutData=0xF0F0, SelB=0, Op=ADD, SelA=01 → o_Acc=0xF16B, Neg=1, Carry=0. Then Acc=0xFFFF + OutData 0x0001 → 0x0000, Zero=1, Carry=1.
- SUB/SRA: Acc=0x0005 minus Operand 0x005 → 0x0000, Zero=1, Carry=0. Then Acc=0x8001, SRA1 → 0xC000, Neg=1, Carry=1.
- Multiply: Acc=0x0012, Operand=0x00D, SelB=1, MulStart pulse.
  - o_Busy high for 17 cycles, then o_MulDone pulse with o_Acc=0x00EA, Carry=0.
  - A WrAcc pulse issued during busy leaves o_Acc unchanged.
- Abort: start a multiply, drop i_reset after 5 cycles → o_Busy=0, o_Acc=0, no o_MulDone. After release, a new multiply completes normally.

Source files
------------

// File: rtl/acc_datapath_pkg.sv
// Shared encodings for the accumulator datapath: ALU ops, accumulator/B-operand
// selects, status flag bundle and the multiplier FSM states.
package acc_datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SHL1  = 3'b101,
        OP_SRA1  = 3'b110,
        OP_PASSB = 3'b111
    } aluOpType;

    typedef enum logic [1:0] {
        SELA_MEM  = 2'b00,
        SELA_ALU  = 2'b01,
        SELA_OPND = 2'b10,
        SELA_HOLD = 2'b11
    } selAType;

    typedef enum logic {
        SELB_MEM  = 1'b0,
        SELB_OPND = 1'b1
    } selBType;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mulStateType;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
    } flagsType;

endpackage

// File: rtl/acc_mul_seq.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
// 'finish' flags the cycle whose productNext is the final product.
module acc_mul_seq
    import acc_datapath_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NBITS-1:0]   multiplicand,
    input  logic [NBITS-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic               finish,
    output logic [2*NBITS-1:0] product
);

    localparam int CW = $clog2(NBITS + 1);

    mulStateType        state;
    logic [CW-1:0]      count;
    logic [2*NBITS-1:0] mcand;
    logic [NBITS-1:0]   mplier;
    logic [2*NBITS-1:0] partial;
    logic [2*NBITS-1:0] partialNext;

    assign partialNext = mplier[0] ? partial + mcand : partial;
    assign finish      = (state == MUL_RUN) && (count == CW'(1));
    assign product     = partialNext;

    // NOTE: every register in a clocked block is assigned with <=, so all
    // right-hand sides see pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MUL_IDLE;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand   <= {{NBITS{1'b0}}, multiplicand};
                        mplier  <= multiplier;
                        partial <= '0;
                        count   <= CW'(NBITS);
                        busy    <= 1'b1;
                        state   <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    partial <= partialNext;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        done  <= 1'b1;
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    busy  <= 1'b0;
                    state <= MUL_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/acc_datapath.sv
// BIP-style accumulator datapath: operand extension, ALU, accumulator and flags.
// Define ACC_DATAPATH_MUL_EN to include the iterative multiplier (acc_mul_seq).
module acc_datapath
    import acc_datapath_pkg::*;
#(
    parameter int NBITS_O  = 11,
    parameter int NBITS_D  = 16,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [1:0]         i_SelA,
    input  logic               i_SelB,
    input  logic               i_WrAcc,
    input  logic [2:0]         i_Op,
    input  logic               i_MulStart,
    input  logic [NBITS_O-1:0] i_Operand,
    input  logic [NBITS_D-1:0] i_OutData,
    output logic [NBITS_D-1:0] o_Acc,
    output logic               o_Zero,
    output logic               o_Neg,
    output logic               o_Carry,
    output logic               o_Busy,
    output logic               o_MulDone
);

    logic [NBITS_D-1:0]   acc;
    flagsType             flags;
    logic [NBITS_D-1:0]   operandExt;
    logic [NBITS_D-1:0]   aluB;
    logic [NBITS_D-1:0]   aluResult;
    logic                 aluCarry;
    logic                 mulBusy;
    logic                 mulFinish;
    logic [2*NBITS_D-1:0] mulProduct;

    generate
        if (NBITS_O == NBITS_D) begin : genExtSame
            assign operandExt = i_Operand;
        end else begin : genExtPad
            localparam int PAD = NBITS_D - NBITS_O;
            assign operandExt = {{PAD{SIGN_EXT & i_Operand[NBITS_O-1]}}, i_Operand};
        end
    endgenerate

    assign aluB = (selBType'(i_SelB) == SELB_OPND) ? operandExt : i_OutData;

    // NOTE: every output gets a default first, so no path through the case
    // can leave a value unassigned and infer a latch.
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        case (aluOpType'(i_Op))
            OP_ADD:   {aluCarry, aluResult} = {1'b0, acc} + {1'b0, aluB};
            OP_SUB: begin
                aluResult = acc - aluB;
                aluCarry  = (acc < aluB);
            end
            OP_AND:   aluResult = acc & aluB;
            OP_OR:    aluResult = acc | aluB;
            OP_XOR:   aluResult = acc ^ aluB;
            OP_SHL1: begin
                aluResult = {acc[NBITS_D-2:0], 1'b0};
                aluCarry  = acc[NBITS_D-1];
            end
            OP_SRA1: begin
                aluResult = {acc[NBITS_D-1], acc[NBITS_D-1:1]};
                aluCarry  = acc[0];
            end
            OP_PASSB: aluResult = aluB;
            default:  aluResult = '0;
        endcase
    end

`ifdef ACC_DATAPATH_MUL_EN
    logic mulDone;

    // Multiplicand is the pre-edge accumulator, so a same-edge write and
    // start multiply the old value.
    acc_mul_seq #(
        .NBITS (NBITS_D)
    ) uMul (
        .clk          (i_clock),
        .rst_n        (i_reset),
        .start        (i_MulStart),
        .multiplicand (acc),
        .multiplier   (aluB),
        .busy         (mulBusy),
        .done         (mulDone),
        .finish       (mulFinish),
        .product      (mulProduct)
    );

    assign o_MulDone = mulDone;
`else
    logic unusedMulStart;

    assign unusedMulStart = i_MulStart;
    assign mulBusy        = 1'b0;
    assign mulFinish      = 1'b0;
    assign mulProduct     = '0;
    assign o_MulDone      = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc   <= '0;
            flags <= '0;
        end else if (mulFinish) begin
            acc         <= mulProduct[NBITS_D-1:0];
            flags.zero  <= (mulProduct[NBITS_D-1:0] == '0);
            flags.neg   <= mulProduct[NBITS_D-1];
            flags.carry <= |mulProduct[2*NBITS_D-1:NBITS_D];
        end else if (i_WrAcc && !mulBusy) begin
            case (selAType'(i_SelA))
                SELA_MEM:  acc <= i_OutData;
                SELA_ALU: begin
                    acc         <= aluResult;
                    flags.zero  <= (aluResult == '0);
                    flags.neg   <= aluResult[NBITS_D-1];
                    flags.carry <= aluCarry;
                end
                SELA_OPND: acc <= operandExt;
                default:   acc <= acc;
            endcase
        end
    end

    assign o_Acc   = acc;
    assign o_Zero  = flags.zero;
    assign o_Neg   = flags.neg;
    assign o_Carry = flags.carry;
    assign o_Busy  = mulBusy;

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath: cycle model plus directed literal checks.
// Multiplier scenarios run when ACC_DATAPATH_MUL_EN is defined.
`timescale 1ns/1ps
module tb_acc_datapath;

`ifdef ACC_DATAPATH_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int ND = 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  selA;
    logic        selB;
    logic        wrAcc;
    logic [2:0]  op;
    logic        mulStart;
    logic [10:0] operand;
    logic [15:0] outData;

    logic [15:0] acc;
    logic        zero, neg, carry, busy, mulDone;
    logic [15:0] acc0;
    logic        zero0, neg0, carry0, busy0, mulDone0;

    int checks = 0;
    int errors = 0;

    acc_datapath #(.NBITS_O(11), .NBITS_D(16), .SIGN_EXT(1'b1)) dut (
        .i_clock(clk), .i_reset(rstN), .i_SelA(selA), .i_SelB(selB),
        .i_WrAcc(wrAcc), .i_Op(op), .i_MulStart(mulStart),
        .i_Operand(operand), .i_OutData(outData),
        .o_Acc(acc), .o_Zero(zero), .o_Neg(neg), .o_Carry(carry),
        .o_Busy(busy), .o_MulDone(mulDone)
    );

    acc_datapath #(.NBITS_O(11), .NBITS_D(16), .SIGN_EXT(1'b0)) dut0 (
        .i_clock(clk), .i_reset(rstN), .i_SelA(selA), .i_SelB(selB),
        .i_WrAcc(wrAcc), .i_Op(op), .i_MulStart(mulStart),
        .i_Operand(operand), .i_OutData(outData),
        .o_Acc(acc0), .o_Zero(zero0), .o_Neg(neg0), .o_Carry(carry0),
        .o_Busy(busy0), .o_MulDone(mulDone0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mAcc;
    logic        mZero, mNeg, mCarry;
    int          mBusyLeft;
    logic [31:0] mProd;

    function automatic logic [15:0] extend(input logic [10:0] v);
        return 16'($signed(v));
    endfunction

    // Returns {carry, result}
    function automatic logic [16:0] aluModel(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua = 32'(a);
        int unsigned ub = 32'(b);
        case (opc)
            3'd0: return 17'(ua + ub);
            3'd1: return {ua < ub, 16'(ua - ub)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {a[15], 16'(ua * 2)};
            3'd6: return {a[0], 16'($signed(a) >>> 1)};
            default: return {1'b0, b};
        endcase
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mAcc = '0; mZero = 1'b0; mNeg = 1'b0; mCarry = 1'b0;
            mBusyLeft = 0; mProd = '0;
        end else begin
            logic [15:0] b;
            logic [15:0] oldAcc;
            logic [16:0] r;
            b = selB ? extend(operand) : outData;
            oldAcc = mAcc;
            if (mBusyLeft > 0) begin
                mBusyLeft--;
                if (mBusyLeft == 1) begin
                    mAcc   = mProd[15:0];
                    mZero  = (mProd[15:0] == 16'h0);
                    mNeg   = mProd[15];
                    mCarry = (mProd[31:16] != 16'h0);
                end
            end else begin
                if (wrAcc) begin
                    case (selA)
                        2'b00: mAcc = outData;
                        2'b01: begin
                            r = aluModel(op, oldAcc, b);
                            mAcc = r[15:0];
                            mZero = (r[15:0] == 16'h0);
                            mNeg = r[15];
                            mCarry = r[16];
                        end
                        2'b10: mAcc = extend(operand);
                        default: ;
                    endcase
                end
                if (MUL_EN && mulStart) begin
                    mProd = {16'h0, oldAcc} * {16'h0, b};
                    mBusyLeft = ND + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_acc", 32'(acc), 32'(mAcc));
        check("m_zero", 32'(zero), 32'(mZero));
        check("m_neg", 32'(neg), 32'(mNeg));
        check("m_carry", 32'(carry), 32'(mCarry));
        check("m_busy", 32'(busy), 32'(mBusyLeft > 0));
        check("m_done", 32'(mulDone), 32'(mBusyLeft == 1));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] sa, input logic [2:0] opc, input logic sb,
                         input logic [10:0] opnd, input logic [15:0] od);
        selA = sa; op = opc; selB = sb; operand = opnd; outData = od; wrAcc = 1'b1;
        tick();
        wrAcc = 1'b0;
    endtask

    task automatic flags(input string name, input logic z, input logic n, input logic c);
        check({name, "_zero"}, 32'(zero), 32'(z));
        check({name, "_neg"}, 32'(neg), 32'(n));
        check({name, "_carry"}, 32'(carry), 32'(c));
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 40 && busy; i++) tick();
        check({name, "_timeout"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; selA = 2'b00; selB = 1'b0; wrAcc = 1'b0; op = 3'd0;
        mulStart = 1'b0; operand = '0; outData = '0;
        tick(); tick();
        rstN = 1'b1;
        tick();
        check("rst_acc", 32'(acc), 32'h0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_busy", 32'(busy), 32'(0));

        // Operand loads leave flags alone
        write(2'b10, 3'd0, 1'b0, 11'h07B, 16'h0);
        check("opnd_07b", 32'(acc), 32'h007B);
        write(2'b10, 3'd0, 1'b0, 11'h7FF, 16'h0);
        check("opnd_sext", 32'(acc), 32'hFFFF);
        check("opnd_zext", 32'(acc0), 32'h07FF);
        flags("opnd", 1'b0, 1'b0, 1'b0);

        // ADD
        write(2'b10, 3'd0, 1'b0, 11'h07B, 16'h0);
        write(2'b01, 3'd0, 1'b0, 11'h0, 16'hF0F0);
        check("add1", 32'(acc), 32'hF16B);
        flags("add1", 1'b0, 1'b1, 1'b0);
        write(2'b10, 3'd0, 1'b0, 11'h7FF, 16'h0);
        write(2'b01, 3'd0, 1'b0, 11'h0, 16'h0001);
        check("add_wrap", 32'(acc), 32'h0000);
        flags("add_wrap", 1'b1, 1'b0, 1'b1);

        // SUB and borrow
        write(2'b10, 3'd0, 1'b0, 11'h005, 16'h0);
        write(2'b01, 3'd1, 1'b1, 11'h005, 16'h0);
        check("sub_zero", 32'(acc), 32'h0000);
        flags("sub_zero", 1'b1, 1'b0, 1'b0);
        write(2'b01, 3'd1, 1'b1, 11'h001, 16'h0);
        check("sub_borrow", 32'(acc), 32'hFFFF);
        flags("sub_borrow", 1'b0, 1'b1, 1'b1);

        // Memory load, shifts, logic ops, PASSB, hold
        write(2'b00, 3'd0, 1'b0, 11'h0, 16'h8001);
        check("mem_load", 32'(acc), 32'h8001);
        write(2'b01, 3'd6, 1'b0, 11'h0, 16'h0);
        check("sra1", 32'(acc), 32'hC000);
        flags("sra1", 1'b0, 1'b1, 1'b1);
        write(2'b01, 3'd5, 1'b0, 11'h0, 16'h0);
        check("shl1", 32'(acc), 32'h8000);
        flags("shl1", 1'b0, 1'b1, 1'b1);
        write(2'b01, 3'd4, 1'b0, 11'h0, 16'hFFFF);
        check("xor", 32'(acc), 32'h7FFF);
        flags("xor", 1'b0, 1'b0, 1'b0);
        write(2'b01, 3'd2, 1'b0, 11'h0, 16'h00F0);
        check("and", 32'(acc), 32'h00F0);
        write(2'b01, 3'd3, 1'b1, 11'h400, 16'h0);
        check("or_sext", 32'(acc), 32'hFCF0);
        write(2'b01, 3'd7, 1'b0, 11'h0, 16'h1234);
        check("passb", 32'(acc), 32'h1234);
        write(2'b11, 3'd0, 1'b0, 11'h0, 16'hAAAA);
        check("hold", 32'(acc), 32'h1234);
        selA = 2'b00; outData = 16'h5555; tick();
        check("no_wr", 32'(acc), 32'h1234);

`ifdef ACC_DATAPATH_MUL_EN
        begin
            int busyCycles = 0;
            int doneCount = 0;
            logic [15:0] accAtDone = '0;
            logic carryAtDone = 1'b1;
            logic [15:0] accMid = '0;
            write(2'b10, 3'd0, 1'b0, 11'h012, 16'h0);
            selB = 1'b1; operand = 11'h00D; mulStart = 1'b1;
            tick();
            mulStart = 1'b0;
            for (int i = 0; i < 40 && busy; i++) begin
                busyCycles++;
                if (mulDone) begin
                    doneCount++;
                    accAtDone = acc;
                    carryAtDone = carry;
                end
                if (i == 5) accMid = acc;
                if (i == 3) begin
                    selA = 2'b10; operand = 11'h155; wrAcc = 1'b1; mulStart = 1'b1;
                end else begin
                    wrAcc = 1'b0; mulStart = 1'b0;
                end
                tick();
            end
            wrAcc = 1'b0; mulStart = 1'b0;
            check("mul_busy_cycles", 32'(busyCycles), 32'd17);
            check("mul_done_pulses", 32'(doneCount), 32'd1);
            check("mul_acc_at_done", 32'(accAtDone), 32'h00EA);
            check("mul_carry", 32'(carryAtDone), 32'(0));
            check("mul_wr_blocked", 32'(accMid), 32'h0012);
            check("mul_acc_after", 32'(acc), 32'h00EA);
        end

        // Back-to-back start with a simultaneous write: multiplier uses old acc
        selA = 2'b10; selB = 1'b1; operand = 11'h7FF; wrAcc = 1'b1; mulStart = 1'b1;
        tick();
        wrAcc = 1'b0; mulStart = 1'b0;
        check("mul2_busy", 32'(busy), 32'(1));
        check("mul2_acc_written", 32'(acc), 32'hFFFF);
        waitIdle("mul2");
        check("mul2_acc", 32'(acc), 32'hFF16);
        flags("mul2", 1'b0, 1'b1, 1'b1);

        // Abort via reset mid-multiply, then a clean multiply
        write(2'b10, 3'd0, 1'b0, 11'h003, 16'h0);
        selB = 1'b1; operand = 11'h005; mulStart = 1'b1;
        tick();
        mulStart = 1'b0;
        repeat (5) tick();
        #2 rstN = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_acc", 32'(acc), 32'h0);
        check("abort_done", 32'(mulDone), 32'(0));
        tick();
        rstN = 1'b1;
        tick();
        write(2'b10, 3'd0, 1'b0, 11'h00C, 16'h0);
        selB = 1'b1; operand = 11'h00B; mulStart = 1'b1;
        tick();
        mulStart = 1'b0;
        waitIdle("mul3");
        check("mul3_acc", 32'(acc), 32'h0084);
`else
        write(2'b10, 3'd0, 1'b0, 11'h012, 16'h0);
        selB = 1'b1; operand = 11'h00D; mulStart = 1'b1;
        tick();
        mulStart = 1'b0;
        check("nomul_busy", 32'(busy), 32'(0));
        write(2'b10, 3'd0, 1'b0, 11'h055, 16'h0);
        check("nomul_write", 32'(acc), 32'h0055);
        check("nomul_done", 32'(mulDone), 32'(0));
`endif

        // Asynchronous reset mid-traffic
        write(2'b00, 3'd0, 1'b0, 11'h0, 16'h8001);
        write(2'b01, 3'd6, 1'b0, 11'h0, 16'h0);
        check("pre_rst_acc", 32'(acc), 32'hC000);
        selA = 2'b01; op = 3'd0; selB = 1'b0; outData = 16'h0001; wrAcc = 1'b1;
        #2 rstN = 1'b0;
        #1;
        check("async_rst_acc", 32'(acc), 32'h0);
        flags("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_rst_busy", 32'(busy), 32'(0));
        wrAcc = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        check("post_rst_acc", 32'(acc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
